reset_sequencer: RTL and testbench

- Parametrised successor to the single-output reset generator.
- Synchronises and filters an external asynchronous active-low reset request, and accepts a software reset pulse.
- Drives NUM_OUT active-low reset outputs, released one at a time in index order, with a programmable hold and stagger.
- Sits at the top of each subsystem and feeds the per-block resets. Reports sequencing status and the cause of the last reset.

---
 rtl/reset_seq_pkg.sv | 31 +++
 rtl/reset_sync.sv | 35 +++
 rtl/reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_reset_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// ============================================================================
// reset_seq_pkg : shared types, cause codes and sizing helper for the
//                 reset sequencer.              Revision: 1.0
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [1:0] {
    FILTER  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // One counter serves every phase, so it is sized for the longest one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync.sv
// ============================================================================
// reset_sync : STAGES-deep flop chain for bringing a reset request into the
//              clk domain, with a parametrised reset value.  Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("reset_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : filters an external/software reset request and releases
//                   NUM_OUT active-low resets in index order.  Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rst_req_n_async,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               seq_done,
  output logic               busy,
  output logic [1:0]         last_cause
);

  if (NUM_OUT < 1 || NUM_OUT > 16 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      FILTER_CYCLES < 1 || FILTER_CYCLES > 255 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      STAGGER_CYCLES < 0 || STAGGER_CYCLES > 65535) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  localparam int CNT_W = cnt_width(FILTER_CYCLES, HOLD_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST =
    CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  logic               req_n_s;
  logic               req_ext;
  logic               req_now;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rel_q, rel_d;
  logic [1:0]         cause_q, cause_d;

  reset_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rst_req_n_async),
    .q_o (req_n_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILTER;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      cause_q <= cause_d;
    end
  end

  assign req_ext = ~req_n_s;
  assign req_now = req_ext | sw_rst_req;
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    cause_d = cause_q;
    if (req_now) begin
      state_d = FILTER;
      cnt_d   = '0;
      idx_d   = '0;
      rel_d   = '0;
      // An external request still held low while filtering is the same reset,
      // so only a fresh request (or any software pulse) rewrites the cause.
      if (sw_rst_req || state_q != FILTER) begin
        if (sw_rst_req && req_ext) begin
          cause_d = CAUSE_BOTH;
        end else if (sw_rst_req) begin
          cause_d = CAUSE_SW;
        end else begin
          cause_d = CAUSE_EXT;
        end
      end
    end else begin
      case (state_q)
        FILTER: begin
          if (cnt_q == FILT_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = (STAGGER_CYCLES == 0) ? {NUM_OUT{1'b1}} : NUM_OUT'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RELEASE: begin
          if (STAGGER_CYCLES == 0 || idx_q == IDX_LAST) begin
            state_d = DONE;
          end else if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            rel_d = rel_q | (rel_q << 1);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = FILTER;
        end
      endcase
    end
  end

  assign rst_n_out  = rel_q;
  assign seq_done   = &rel_q;
  assign busy       = ~seq_done;
  assign last_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : three parameterisations of reset_sequencer driven by
//                      shared random/directed stimulus.   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  localparam int CFG_N [3] = '{4, 1, 4};
  localparam int CFG_SS[3] = '{2, 2, 3};
  localparam int CFG_F [3] = '{4, 4, 1};
  localparam int CFG_H [3] = '{16, 16, 3};
  localparam int CFG_S [3] = '{8, 0, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_req_n_async;
  logic       sw_rst_req;
  logic [3:0] rn0;
  logic [0:0] rn1;
  logic [3:0] rn2;
  logic [2:0] done_o, busy_o;
  logic [1:0] cause0, cause1, cause2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_OUT(4), .SYNC_STAGES(2), .FILTER_CYCLES(4),
                    .HOLD_CYCLES(16), .STAGGER_CYCLES(8)) u_dut0 (
    .clk(clk), .rst(rst), .rst_req_n_async(rst_req_n_async), .sw_rst_req(sw_rst_req),
    .rst_n_out(rn0), .seq_done(done_o[0]), .busy(busy_o[0]), .last_cause(cause0));

  reset_sequencer #(.NUM_OUT(1), .SYNC_STAGES(2), .FILTER_CYCLES(4),
                    .HOLD_CYCLES(16), .STAGGER_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .rst_req_n_async(rst_req_n_async), .sw_rst_req(sw_rst_req),
    .rst_n_out(rn1), .seq_done(done_o[1]), .busy(busy_o[1]), .last_cause(cause1));

  reset_sequencer #(.NUM_OUT(4), .SYNC_STAGES(3), .FILTER_CYCLES(1),
                    .HOLD_CYCLES(3), .STAGGER_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .rst_req_n_async(rst_req_n_async), .sw_rst_req(sw_rst_req),
    .rst_n_out(rn2), .seq_done(done_o[2]), .busy(busy_o[2]), .last_cause(cause2));

  typedef struct packed {
    logic [11:0] rn;
    logic [2:0]  done;
    logic [5:0]  cause;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: each output is a threshold on the number of request-free
  // edges since the last request; the filter phase is the first F of those.
  int         m_quiet[3];
  logic [1:0] m_cause[3];
  logic [3:0] m_sync [3];

  always @(posedge clk) begin
    exp_t e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      logic rns, ext, req;
      int   base;
      if (rst) begin
        m_quiet[k] = 0;
        m_cause[k] = 2'b00;
        m_sync[k]  = 4'b0000;
      end else begin
        rns = m_sync[k][CFG_SS[k]-1];
        ext = ~rns;
        req = ext | sw_rst_req;
        if (req) begin
          if (sw_rst_req || m_quiet[k] >= CFG_F[k]) m_cause[k] = {sw_rst_req, ext};
          m_quiet[k] = 0;
        end else if (m_quiet[k] < 1000000) begin
          m_quiet[k] = m_quiet[k] + 1;
        end
        m_sync[k] = {m_sync[k][2:0], rst_req_n_async};
      end
      base = CFG_F[k] + CFG_H[k];
      for (int i = 0; i < CFG_N[k]; i++)
        e.rn[k*4 + i] = (m_quiet[k] >= base + i * CFG_S[k]);
      e.done[k]        = (m_quiet[k] >= base + (CFG_N[k] - 1) * CFG_S[k]);
      e.cause[k*2 +: 2] = m_cause[k];
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty at %0t: actual=0 expected=1 entries", $time);
    end else begin
      e = exp_q.pop_front();
      check("rst_n_out0",  rn0,                 e.rn[3:0]);
      check("rst_n_out1",  {3'b000, rn1},       {3'b000, e.rn[4]});
      check("rst_n_out2",  rn2,                 e.rn[11:8]);
      check("seq_done",    {1'b0, done_o},      {1'b0, e.done});
      check("busy",        {1'b0, busy_o},      {1'b0, ~e.done});
      check("last_cause0", {2'b00, cause0},     {2'b00, e.cause[1:0]});
      check("last_cause1", {2'b00, cause1},     {2'b00, e.cause[3:2]});
      check("last_cause2", {2'b00, cause2},     {2'b00, e.cause[5:4]});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    int found;
    rst             = 1'b1;
    rst_req_n_async = 1'b1;
    sw_rst_req      = 1'b0;

    // Power-on sequence
    tick(5);
    rst = 1'b0;
    tick(60);

    // Single-cycle external glitch from DONE
    rst_req_n_async = 1'b0;
    tick(1);
    rst_req_n_async = 1'b1;
    tick(60);

    // Filter restart: high 3, low 1, then steady high
    rst_req_n_async = 1'b0;
    tick(5);
    rst_req_n_async = 1'b1;
    tick(3);
    rst_req_n_async = 1'b0;
    tick(1);
    rst_req_n_async = 1'b1;

    // Software pulse while the default instance shows 0011
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      tick(1);
      if (rn0 == 4'b0011) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL wait_0011: actual=%b expected=0011 within 200 cycles", rn0);
    end
    sw_pulse();
    tick(60);

    // Software pulse in the same cycle the synchronised request falls
    rst_req_n_async = 1'b0;
    tick(2);
    sw_rst_req      = 1'b1;
    rst_req_n_async = 1'b1;
    tick(1);
    sw_rst_req      = 1'b0;
    tick(60);

    // Software pulse during the filter phase restarts it
    sw_pulse();
    tick(2);
    sw_pulse();
    tick(50);

    // Random phases: quiet stretches separated by disturbances
    for (int r = 0; r < 14; r++) begin
      tick($urandom_range(5, 70));
      case ($urandom_range(0, 4))
        0: begin
          rst_req_n_async = 1'b0;
          tick($urandom_range(1, 4));
          rst_req_n_async = 1'b1;
        end
        1: sw_pulse();
        2: begin
          rst_req_n_async = 1'b0;
          tick($urandom_range(0, 3));
          sw_pulse();
          rst_req_n_async = 1'b1;
        end
        3: begin
          rst = 1'b1;
          tick($urandom_range(1, 3));
          rst = 1'b0;
        end
        default: begin
          sw_pulse();
          tick($urandom_range(0, 2));
          sw_pulse();
        end
      endcase
    end
    tick(60);

    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
